// File: rtl/race_pkg.sv
// Shared encodings, screen geometry and lane decode for the race game engine.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2
  } state_t;

  localparam logic [9:0] LANE0    = 10'd159;
  localparam logic [9:0] LANE1    = 10'd295;
  localparam logic [9:0] LANE2    = 10'd431;
  localparam logic [8:0] CAR_Y    = 9'd400;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [8:0] OBJ_SIZE = 9'd50;

  // An obstacle overlaps the car vertically strictly inside this window.
  localparam logic [8:0] HIT_V_LO = CAR_Y - OBJ_SIZE;
  localparam logic [8:0] HIT_V_HI = CAR_Y + OBJ_SIZE;

  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    case (sel)
      2'd1:    lane_x = LANE1;
      2'd2:    lane_x = LANE2;
      default: lane_x = LANE0;
    endcase
  endfunction

endpackage

// File: rtl/race_btn_sync.sv
// Two-flop synchronizer for a raw button followed by rising-edge detection.
module race_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], btn};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/race_game_ctrl.sv
// Per-frame game-state engine: car lane, two falling obstacles, LFSR, score and speed.
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int unsigned SPEED_INIT = 4,
  parameter int unsigned SPEED_MAX  = 12,
  parameter logic [9:0]  LFSR_SEED  = 10'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [9:0] carro_h_pos,
  output logic [8:0] carro_v_pos,
  output logic [9:0] obs1_h_pos,
  output logic [8:0] obs1_v_pos,
  output logic [9:0] obs2_h_pos,
  output logic [8:0] obs2_v_pos,
  output logic [9:0] lfsr,
  output logic [7:0] score,
  output logic [1:0] game_state
);

  localparam logic [3:0] SPD_INIT = SPEED_INIT[3:0];
  localparam logic [3:0] SPD_MAX  = SPEED_MAX[3:0];

  state_t      state, state_nx;
  logic        left_p, right_p, start_p;
  logic [1:0]  car_lane, lane_nx;
  logic [3:0]  speed, speed_nx;
  logic        hit1, hit2, crash_now, advance, wrap1, wrap2;
  logic [9:0]  nv1, nv2;
  logic [8:0]  score_sum;
  logic [7:0]  score_nx;

  race_btn_sync u_sync_left  (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .pulse(left_p));
  race_btn_sync u_sync_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .pulse(right_p));
  race_btn_sync u_sync_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p));

  assign game_state  = state;
  assign carro_v_pos = CAR_Y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    hit1      = (obs1_h_pos == carro_h_pos) && (obs1_v_pos > HIT_V_LO) && (obs1_v_pos < HIT_V_HI);
    hit2      = (obs2_h_pos == carro_h_pos) && (obs2_v_pos > HIT_V_LO) && (obs2_v_pos < HIT_V_HI);
    crash_now = (state == ST_RUN) && frame_tick && (hit1 || hit2);
    advance   = (state == ST_RUN) && frame_tick && !(hit1 || hit2);

    nv1   = {1'b0, obs1_v_pos} + {6'd0, speed};
    nv2   = {1'b0, obs2_v_pos} + {6'd0, speed};
    wrap1 = (nv1 >= SCREEN_H);
    wrap2 = (nv2 >= SCREEN_H);

    score_sum = {1'b0, score} + {8'd0, wrap1} + {8'd0, wrap2};
    score_nx  = score_sum[8] ? '1 : score_sum[7:0];
    // At most +2 per tick, so at most one multiple of 8 is crossed.
    speed_nx  = ((score_nx[7:3] != score[7:3]) && (speed < SPD_MAX)) ? speed + 4'd1 : speed;

    lane_nx = car_lane;
    if (left_p && !right_p && (car_lane != 2'd0)) lane_nx = car_lane - 2'd1;
    if (right_p && !left_p && (car_lane != 2'd2)) lane_nx = car_lane + 2'd1;

    state_nx = state;
    case (state)
      ST_IDLE:  if (start_p)   state_nx = ST_RUN;
      ST_RUN:   if (crash_now) state_nx = ST_CRASH;
      ST_CRASH: if (start_p)   state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= LFSR_SEED;
      car_lane    <= 2'd1;
      carro_h_pos <= LANE1;
      obs1_h_pos  <= LANE0;
      obs1_v_pos  <= '0;
      obs2_h_pos  <= LANE2;
      obs2_v_pos  <= 9'd240;
      score       <= '0;
      speed       <= SPD_INIT;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if ((state == ST_CRASH) && start_p) begin
        car_lane    <= 2'd1;
        carro_h_pos <= LANE1;
        obs1_h_pos  <= LANE0;
        obs1_v_pos  <= '0;
        obs2_h_pos  <= LANE2;
        obs2_v_pos  <= 9'd240;
        score       <= '0;
        speed       <= SPD_INIT;
      end else if (state == ST_RUN) begin
        if (!crash_now) begin
          car_lane    <= lane_nx;
          carro_h_pos <= lane_x(lane_nx);
        end
        if (advance) begin
          if (wrap1) begin
            obs1_v_pos <= '0;
            obs1_h_pos <= lane_x(lfsr[1:0]);
          end else begin
            obs1_v_pos <= nv1[8:0];
          end
          if (wrap2) begin
            obs2_v_pos <= '0;
            obs2_h_pos <= lane_x(lfsr[3:2]);
          end else begin
            obs2_v_pos <= nv2[8:0];
          end
          score <= score_nx;
          speed <= speed_nx;
        end
      end
    end
  end

endmodule
